shifter_seq: RTL
================

// Module: shifter_seq
//
// PURPOSE
// - Multi-cycle shift/rotate unit: counterpart to the single-cycle shifter stages in the execute datapath.
//   Applies a 0-15 bit shift iteratively, at most STEP bits per cycle, for area-reduced builds.
// - Sits beside the ALU in execute, uses the shifter op encoding, and stalls the pipe via busy
//   until done pulses.
//
// PARAMETERS
// - WIDTH  16  data width; cnt width is log2(WIDTH)=4
// - STEP   1   max bits shifted per cycle; legal 1,2,4,8
//
// PORTS
// - clk    in   1      single clock; all state updates on posedge clk
// - rst    in   1      synchronous, active-high reset
// - start  in   1      request; sampled only when busy=0
// - in     in   16     operand
// - op     in   3      000 ROL, 001 ROR, 010 SLL, 011 SRA, 100 SRL, 101-111 illegal
// - cnt    in   4      shift amount 0..15
// - busy   out  1      high while shifting (state SHIFT)
// - done   out  1      one-cycle pulse: out valid and new this cycle
// - err    out  1      valid with done: op was illegal
// - out    out  16     result register; holds value until the next done
//
// BEHAVIOUR
// - Reset (synchronous, rst=1 at posedge): state=IDLE, busy=0, done=0, err=0, out=16'h0000,
//   internal data/op/remaining cleared. Reset mid-operation abandons it; no done issued.
// - States: IDLE, SHIFT, DONE. busy=(state==SHIFT); done=(state==DONE).
// - IDLE/DONE + start=1: latch in->data, op, cnt->rem. If op illegal or cnt==0 -> DONE, else -> SHIFT.
// - IDLE/DONE + start=0 -> IDLE. DONE lasts exactly one cycle unless a new start is accepted.
// - start while busy=1 is ignored; operands and progress unchanged.
// - SHIFT each cycle: k=min(rem,STEP); data<=op_step(data,op,k); rem<=rem-k; rem-k==0 -> DONE.
// - Entering DONE: out<=data; err<=illegal. Illegal op: out<=in unchanged, err=1.
// - Latency (start edge to done high): 1 cycle if cnt==0 or illegal, else ceil(cnt/STEP)+1 cycles.
// - Shift rules per bit: ROL {d[14:0],d[15]}; ROR {d[0],d[15:1]}; SLL {d[14:0],0};
//   SRA {d[15],d[15:1]}; SRL {0,d[15:1]}. k-bit step equals k repeated 1-bit steps.
// - err deasserted whenever done is low. out not modified while in SHIFT.
//
// STRUCTURE
// - Shared include shifter_defs.vh: op codes (SH_ROL..SH_SRL), state encodings, WIDTH default;
//   the single-cycle shifter stages use the same op codes.
// - One sub-module: shift_step (combinational; data, op, k -> shifted data, k in 0..STEP).
// - This module: FSM, rem counter, data/op/out registers.
//
// TESTING (STEP=1 unless stated)
// - ROL in=16'h8001 cnt=1 -> done 2 cycles after start, out=16'h0003, err=0.
// - SRA in=16'h8000 cnt=15 -> busy 15 cycles, done at cycle 16, out=16'hFFFF; SRL same -> 16'h0001.
// - ROR in=16'h1234 cnt=4 -> 16'h4123; STEP=4 build: same result, done 2 cycles after start.
// - cnt=0, SLL in=16'h00FF -> done next cycle, out=16'h00FF; op=3'b110 -> done next cycle, err=1.
// - start pulsed mid-SHIFT with other operands -> ignored, original result delivered; then
//   back-to-back start in DONE cycle accepted.
// - rst asserted at cycle 3 of a cnt=10 op -> next cycle busy=0, done=0, out=0; no done follows.

Source files
------------

// File: rtl/shifter_seq_pkg.sv
// Shared definitions for the multi-cycle shifter: op codes, FSM states and widths.
// The op codes match the single-cycle shifter stages in the execute datapath.
package shifter_seq_pkg;

  localparam int unsigned WIDTH_DEF = 16;
  localparam int unsigned OP_W      = 3;

  localparam logic [OP_W-1:0] SH_ROL = 3'b000;
  localparam logic [OP_W-1:0] SH_ROR = 3'b001;
  localparam logic [OP_W-1:0] SH_SLL = 3'b010;
  localparam logic [OP_W-1:0] SH_SRA = 3'b011;
  localparam logic [OP_W-1:0] SH_SRL = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

  // Codes above SRL are reserved and flagged as illegal.
  function automatic logic op_illegal(input logic [OP_W-1:0] op);
    return op > SH_SRL;
  endfunction

endpackage

// File: rtl/shifter_seq_step.sv
// Combinational shift stage: applies k (0..STEP) single-bit steps of the given op.
module shift_step
  import shifter_seq_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned STEP  = 1,
  localparam int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] data,
  input  logic [OP_W-1:0]  op,
  input  logic [CNT_W-1:0] k,
  output logic [WIDTH-1:0] result
);

  function automatic logic [WIDTH-1:0] shift1(input logic [WIDTH-1:0] d,
                                               input logic [OP_W-1:0] o);
    logic [WIDTH-1:0] r;
    r = d;
    case (o)
      SH_ROL:  r = {d[WIDTH-2:0], d[WIDTH-1]};
      SH_ROR:  r = {d[0], d[WIDTH-1:1]};
      SH_SLL:  r = {d[WIDTH-2:0], 1'b0};
      SH_SRA:  r = {d[WIDTH-1], d[WIDTH-1:1]};
      SH_SRL:  r = {1'b0, d[WIDTH-1:1]};
      default: r = d;
    endcase
    return r;
  endfunction

  // A k-bit step is k chained 1-bit steps; the chain is unrolled to STEP stages.
  always_comb begin
    result = data;
    for (int unsigned i = 0; i < STEP; i++) begin
      if (CNT_W'(i) < k) result = shift1(result, op);
    end
  end

endmodule

// File: rtl/shifter_seq.sv
// Multi-cycle shift/rotate unit: shifts at most STEP bits per cycle, holds busy
// while shifting and pulses done with the registered result.
module shifter_seq
  import shifter_seq_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned STEP  = 1,
  localparam int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in,
  input  logic [OP_W-1:0]  op,
  input  logic [CNT_W-1:0] cnt,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] out
);

  state_e           state, state_next;
  logic [WIDTH-1:0] data, data_next, stepped, out_next;
  logic [OP_W-1:0]  op_q, op_next;
  logic [CNT_W-1:0] rem, rem_next, k, rem_after;
  logic             accept, err_next;

  assign accept    = start && (state != ST_SHIFT);
  assign k         = (rem < CNT_W'(STEP)) ? rem : CNT_W'(STEP);
  assign rem_after = rem - k;

  shift_step #(.WIDTH(WIDTH), .STEP(STEP)) u_step (
    .data   (data),
    .op     (op_q),
    .k      (k),
    .result (stepped)
  );

  // State register plus registered status outputs decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
      out   <= '0;
      data  <= '0;
      op_q  <= '0;
      rem   <= '0;
    end else begin
      state <= state_next;
      busy  <= (state_next == ST_SHIFT);
      done  <= (state_next == ST_DONE);
      err   <= err_next;
      out   <= out_next;
      data  <= data_next;
      op_q  <= op_next;
      rem   <= rem_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_next = (op_illegal(op) || (cnt == '0)) ? ST_DONE : ST_SHIFT;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (rem_after == '0) state_next = ST_DONE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Datapath: operand capture, per-cycle step, result and error update on DONE entry.
  always_comb begin
    data_next = data;
    op_next   = op_q;
    rem_next  = rem;
    out_next  = out;
    err_next  = 1'b0;
    if (accept) begin
      data_next = in;
      op_next   = op;
      rem_next  = cnt;
      if (state_next == ST_DONE) begin
        out_next = in;
        err_next = op_illegal(op);
      end
    end else if (state == ST_SHIFT) begin
      data_next = stepped;
      rem_next  = rem_after;
      if (state_next == ST_DONE) out_next = stepped;
    end
  end

endmodule
